// File: rtl/nn_pkg.sv
// Shared definitions for the image-buffer controller slice: default widths,
// FSM state encoding and the read/write grant encoding.
package nn_pkg;

    localparam int DEF_DATA_WIDTH       = 8;
    localparam int PIXELS_PER_WORD      = 6;
    localparam int DEF_TOTAL_DATA_WIDTH = DEF_DATA_WIDTH * PIXELS_PER_WORD;
    localparam int DEF_DEPTH            = 512;

    // Burst engine states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Which side of the single buffer port was granted
    typedef enum logic {
        GNT_READ  = 1'b0,
        GNT_WRITE = 1'b1
    } grant_t;

endpackage

// File: rtl/nn_bf_rr_arb.sv
// Two-requester round-robin arbiter for the single buffer port.
// A lone requester always wins; on contention the side that was not
// granted most recently wins, so contended traffic alternates.
module nn_bf_rr_arb
    import nn_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic req_wr,
    input  logic req_rd,
    output logic grant_wr,
    output logic grant_rd
);

    grant_t last_grant_reg;

    // Grant decision, purely combinational from the requests and history
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (req_wr && req_rd) begin
            if (last_grant_reg == GNT_READ) begin
                grant_wr = 1'b1;
            end else begin
                grant_rd = 1'b1;
            end
        end else if (req_wr) begin
            grant_wr = 1'b1;
        end else if (req_rd) begin
            grant_rd = 1'b1;
        end
    end

    // Remember the side that used the port last
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_grant_reg <= GNT_READ;
        end else if (grant_wr) begin
            last_grant_reg <= GNT_WRITE;
        end else if (grant_rd) begin
            last_grant_reg <= GNT_READ;
        end
    end

endmodule

// File: rtl/nn_img_bf_ctrl.sv
// Controller for the single-port image buffer. Arbitrates the port between
// the loader write stream and a burst read engine that expands a
// (base, length) command into sequential reads, registering the
// combinational buffer read data into a valid/ready output stream.
module nn_img_bf_ctrl
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH       = 10,
    parameter int TOTAL_DATA_WIDTH = DATA_WIDTH * PIXELS_PER_WORD,
    parameter int DEPTH            = DEF_DEPTH,
    parameter int LEN_WIDTH        = 10
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    // loader write stream
    input  logic                        i_wr_valid,
    output logic                        o_wr_ready,
    input  logic [ADDR_WIDTH-1:0]       i_wr_addr,
    input  logic [TOTAL_DATA_WIDTH-1:0] i_wr_data,
    // burst command
    input  logic                        i_rd_cmd_valid,
    output logic                        o_rd_cmd_ready,
    input  logic [ADDR_WIDTH-1:0]       i_rd_cmd_base,
    input  logic [LEN_WIDTH-1:0]        i_rd_cmd_len,
    // read stream to the PE feeder
    output logic                        o_rd_valid,
    input  logic                        i_rd_ready,
    output logic [TOTAL_DATA_WIDTH-1:0] o_rd_data,
    output logic                        o_rd_last,
    output logic                        o_rd_done,
    output logic                        o_busy,
    output logic                        o_err_addr,
    // buffer port
    output logic                        o_bf_wr_en,
    output logic [ADDR_WIDTH-1:0]       o_bf_wr_addr,
    output logic [TOTAL_DATA_WIDTH-1:0] o_bf_wr_data,
    output logic                        o_bf_rd_en,
    output logic [ADDR_WIDTH-1:0]       o_bf_rd_addr,
    input  logic [TOTAL_DATA_WIDTH-1:0] i_bf_rd_data
);

    // Extra bit so the range check also works when DEPTH == 2**ADDR_WIDTH
    localparam logic [ADDR_WIDTH:0]    DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [LEN_WIDTH-1:0]   LEN_ONE   = LEN_WIDTH'(1);

    state_t                      state_reg;
    state_t                      state_next;
    logic [ADDR_WIDTH-1:0]       cur_addr_reg;
    logic [LEN_WIDTH-1:0]        remaining_reg;
    logic                        rd_valid_reg;
    logic                        rd_last_reg;
    logic [TOTAL_DATA_WIDTH-1:0] rd_data_reg;
    logic                        err_addr_reg;

    logic                        cmd_ready;
    logic                        cmd_fire;
    logic                        last_fire;
    logic                        rd_need;
    logic                        grant_wr;
    logic                        grant_rd;
    logic                        wr_in_range;
    logic [ADDR_WIDTH-1:0]       cur_addr_inc;

    assign cmd_fire     = i_rd_cmd_valid && cmd_ready;
    assign last_fire    = rd_valid_reg && rd_last_reg && i_rd_ready;
    // A read may issue only when the output slot is free or being drained
    assign rd_need      = (state_reg == BURST) && (remaining_reg != '0) &&
                          (!rd_valid_reg || i_rd_ready);
    assign wr_in_range  = ({1'b0, i_wr_addr} < DEPTH_EXT);
    assign cur_addr_inc = (cur_addr_reg >= LAST_ADDR) ? '0 : cur_addr_reg + ADDR_WIDTH'(1);

    // Requests are masked while reset is held so every output sits at 0
    nn_bf_rr_arb u_arb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .req_wr   (i_wr_valid && !i_rst),
        .req_rd   (rd_need && !i_rst),
        .grant_wr (grant_wr),
        .grant_rd (grant_rd)
    );

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_fire) begin
                    state_next = (i_rd_cmd_len == '0) ? DONE : BURST;
                end
            end
            BURST: begin
                if (last_fire) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        cmd_ready = 1'b0;
        o_busy    = 1'b0;
        o_rd_done = 1'b0;
        case (state_reg)
            IDLE:    cmd_ready = !i_rst;
            BURST:   o_busy    = 1'b1;
            DONE:    o_rd_done = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    // Burst address and word counter: loaded by a command, stepped per read issue
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cur_addr_reg  <= '0;
            remaining_reg <= '0;
        end else if (cmd_fire && (i_rd_cmd_len != '0)) begin
            cur_addr_reg  <= i_rd_cmd_base;
            remaining_reg <= i_rd_cmd_len;
        end else if (grant_rd) begin
            cur_addr_reg  <= cur_addr_inc;
            remaining_reg <= remaining_reg - LEN_ONE;
        end
    end

    // Output slot: capture buffer data on issue, drop it once consumed
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_valid_reg <= 1'b0;
            rd_last_reg  <= 1'b0;
            rd_data_reg  <= '0;
        end else if (grant_rd) begin
            rd_valid_reg <= 1'b1;
            rd_last_reg  <= (remaining_reg == LEN_ONE);
            rd_data_reg  <= i_bf_rd_data;
        end else if (rd_valid_reg && i_rd_ready) begin
            rd_valid_reg <= 1'b0;
            rd_last_reg  <= 1'b0;
        end
    end

    // Sticky flag for writes aimed past the implemented depth
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_addr_reg <= 1'b0;
        end else if (grant_wr && !wr_in_range) begin
            err_addr_reg <= 1'b1;
        end
    end

    assign o_rd_cmd_ready = cmd_ready;
    assign o_rd_valid     = rd_valid_reg;
    assign o_rd_last      = rd_last_reg;
    assign o_rd_data      = rd_data_reg;
    assign o_err_addr     = err_addr_reg;

    // Out-of-range writes are handshaken but never reach the buffer
    assign o_wr_ready     = grant_wr;
    assign o_bf_wr_en     = grant_wr && wr_in_range;
    assign o_bf_wr_addr   = grant_wr ? i_wr_addr : '0;
    assign o_bf_wr_data   = grant_wr ? i_wr_data : '0;
    assign o_bf_rd_en     = grant_rd;
    assign o_bf_rd_addr   = grant_rd ? cur_addr_reg : '0;

endmodule
